rf_wb_arbiter: RTL and testbench

- Writer-side front end for the CPU register file. It is the sole driver of the register file write port (rf_we, wR, wD).
- It merges two producers onto that single port:
  - Source A: the in-order pipeline writeback. A never stalls.
  - Source B: long-latency results from the load/multiply unit. B uses a valid/ready handshake and is buffered in a small FIFO.
- It also reports whether a register read would hit a still-queued B write, so decode can stall.

---
 rtl/rf_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: merges the non-stalling pipeline writeback (A)
// with a FIFO-buffered long-latency producer (B), and flags reads of queued B targets.
module rf_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [4:0]    a_wR,
    input  logic [31:0]   a_wD,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [4:0]    b_wR,
    input  logic [31:0]   b_wD,
    input  logic [4:0]    q_rR1,
    input  logic [4:0]    q_rR2,
    output logic          b_hazard,
    output logic          rf_we,
    output logic [4:0]    wR,
    output logic [31:0]   wD,
    output logic [AW:0]   fifo_cnt
);

    localparam logic [AW:0] C_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_EMPTY = {(AW+1){1'b0}};

    logic [4:0]    r_mem_wr [DEPTH];
    logic [31:0]   r_mem_wd [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic          r_rf_we;
    logic [4:0]    r_wr;
    logic [31:0]   r_wd;

    logic          w_full;
    logic          w_empty;
    logic          w_enq;
    logic          w_deq;
    logic [4:0]    w_head_wr;
    logic [31:0]   w_head_wd;
    logic          w_hazard;
    logic [AW-1:0] w_idx;

    // Full/empty are derived from the occupancy count alone; pointers wrap freely.
    assign w_full    = (r_cnt == C_FULL);
    assign w_empty   = (r_cnt == C_EMPTY);
    assign w_enq     = b_valid & ~w_full;
    assign w_deq     = ~a_valid & ~w_empty;
    assign w_head_wr = r_mem_wr[r_rd_ptr];
    assign w_head_wd = r_mem_wd[r_rd_ptr];

    assign b_ready   = ~w_full;
    assign b_hazard  = w_hazard;
    assign rf_we     = r_rf_we;
    assign wR        = r_wr;
    assign wD        = r_wd;
    assign fifo_cnt  = r_cnt;

    // Hazard scan over the occupied window starting at the read pointer.
    always_comb begin
        w_hazard = 1'b0;
        w_idx    = r_rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx    = r_rd_ptr + AW'(k);
            w_hazard = w_hazard |
                       (((AW+1)'(k) < r_cnt) && (r_mem_wr[w_idx] != 5'd0) &&
                        ((r_mem_wr[w_idx] == q_rR1) || (r_mem_wr[w_idx] == q_rR2)));
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every use.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_wr[r_wr_ptr] <= b_wR;
            r_mem_wd[r_wr_ptr] <= b_wD;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_cnt    <= C_EMPTY;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_enq, w_deq})
                2'b10:   r_cnt <= r_cnt + {{AW{1'b0}}, 1'b1};
                2'b01:   r_cnt <= r_cnt - {{AW{1'b0}}, 1'b1};
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Write-port register: A has strict priority, register 0 writes are suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we <= 1'b0;
            r_wr    <= 5'd0;
            r_wd    <= 32'd0;
        end else if (a_valid) begin
            r_rf_we <= (a_wR != 5'd0);
            r_wr    <= a_wR;
            r_wd    <= a_wD;
        end else if (w_deq) begin
            r_rf_we <= (w_head_wr != 5'd0);
            r_wr    <= w_head_wr;
            r_wd    <= w_head_wd;
        end else begin
            r_rf_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, reset/wrap sequences, and random
// traffic checked against a queue-based model of the arbitration rules.
module tb_rf_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid, b_ready, b_hazard, rf_we;
    logic [4:0]  a_wR, b_wR, q_rR1, q_rR2, wR;
    logic [31:0] a_wD, b_wD, wD;
    logic [AW:0] fifo_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  wr;
        logic [31:0] wd;
    } entry_t;
    entry_t mq[$];
    logic        m_we;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    typedef struct {
        logic        av;
        logic [4:0]  aw;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  bw;
        logic [31:0] bd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_rdy;
        logic        e_haz;
        logic        e_we;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic [2:0]  e_cnt;
    } vec_t;
    vec_t tbl[18];

    rf_wb_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_wR(a_wR), .a_wD(a_wD),
        .b_valid(b_valid), .b_ready(b_ready), .b_wR(b_wR), .b_wD(b_wD),
        .q_rR1(q_rR1), .q_rR2(q_rR2), .b_hazard(b_hazard),
        .rf_we(rf_we), .wR(wR), .wD(wD), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_hazard();
        logic h = 1'b0;
        foreach (mq[i])
            if (mq[i].wr != 5'd0 && (mq[i].wr == q_rR1 || mq[i].wr == q_rR2)) h = 1'b1;
        return h;
    endfunction

    task automatic drive(input logic av, input logic [4:0] aw, input logic [31:0] ad,
                         input logic bv, input logic [4:0] bw, input logic [31:0] bd,
                         input logic [4:0] r1, input logic [4:0] r2);
        a_valid = av; a_wR = aw; a_wD = ad;
        b_valid = bv; b_wR = bw; b_wD = bd;
        q_rR1 = r1; q_rR2 = r2;
    endtask

    // Combinational checks before the edge, then advance the model across the edge.
    task automatic pre_edge();
        entry_t head;
        logic   enq;
        #1;
        chk("b_ready", 32'(b_ready), 32'(mq.size() < DEPTH));
        chk("b_hazard", 32'(b_hazard), 32'(model_hazard()));
        chk("fifo_cnt", 32'(fifo_cnt), 32'(mq.size()));
        enq = b_valid && (mq.size() < DEPTH);
        if (a_valid) begin
            m_we = (a_wR != 5'd0); m_wr = a_wR; m_wd = a_wD;
        end else if (mq.size() > 0) begin
            head = mq.pop_front();
            m_we = (head.wr != 5'd0); m_wr = head.wr; m_wd = head.wd;
        end else begin
            m_we = 1'b0;
        end
        if (enq) mq.push_back('{b_wR, b_wD});
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
        chk("rf_we", 32'(rf_we), 32'(m_we));
        chk("wR", 32'(wR), 32'(m_wr));
        chk("wD", wD, m_wd);
    endtask

    task automatic step(input logic av, input logic [4:0] aw, input logic [31:0] ad,
                        input logic bv, input logic [4:0] bw, input logic [31:0] bd,
                        input logic [4:0] r1, input logic [4:0] r2);
        drive(av, aw, ad, bv, bw, bd, r1, r2);
        pre_edge();
        post_edge();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,   5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h1234, 3'd0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,   5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 3'd0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'hDEAD,5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 32'h1234, 3'd1};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,   5'd7, 5'd0, 1'b1, 1'b1, 1'b1, 5'd7, 32'hDEAD, 3'd0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,   5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 5'd7, 32'hDEAD, 3'd0};
        tbl[5]  = '{1'b1, 5'd0, 32'h55,   1'b0, 5'd0, 32'h0,   5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h55,   3'd0};
        tbl[6]  = '{1'b1, 5'd3, 32'hA1,   1'b1, 5'd1, 32'h101, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA1,   3'd1};
        tbl[7]  = '{1'b1, 5'd3, 32'hA2,   1'b1, 5'd2, 32'h102, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA2,   3'd2};
        tbl[8]  = '{1'b1, 5'd3, 32'hA3,   1'b1, 5'd3, 32'h103, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA3,   3'd3};
        tbl[9]  = '{1'b1, 5'd3, 32'hA4,   1'b1, 5'd4, 32'h104, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA4,   3'd4};
        tbl[10] = '{1'b1, 5'd3, 32'hAA,   1'b1, 5'd5, 32'h105, 5'd4, 5'd1, 1'b0, 1'b1, 1'b1, 5'd3, 32'hAA,   3'd4};
        tbl[11] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd6, 32'h106, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'h101,  3'd3};
        tbl[12] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'h109, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd2, 32'h102,  3'd3};
        tbl[13] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,   5'd9, 5'd0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h103,  3'd2};
        tbl[14] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'h1FF, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h104,  3'd2};
        tbl[15] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,   5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 32'h109,  3'd1};
        tbl[16] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,   5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h1FF,  3'd0};
        tbl[17] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,   5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h1FF,  3'd0};

        m_we = 1'b0; m_wr = 5'd0; m_wd = 32'd0;
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        #12;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_wR", 32'(wR), 32'd0);
        chk("rst_wD", wD, 32'd0);
        chk("rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_ready", 32'(b_ready), 32'd1);
        chk("rst_hazard", 32'(b_hazard), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors from the table.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].av, tbl[i].aw, tbl[i].ad, tbl[i].bv, tbl[i].bw, tbl[i].bd, tbl[i].r1, tbl[i].r2);
            pre_edge();
            chk($sformatf("tbl%0d_ready", i), 32'(b_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_hazard", i), 32'(b_hazard), 32'(tbl[i].e_haz));
            post_edge();
            chk($sformatf("tbl%0d_we", i), 32'(rf_we), 32'(tbl[i].e_we));
            chk($sformatf("tbl%0d_wR", i), 32'(wR), 32'(tbl[i].e_wr));
            chk($sformatf("tbl%0d_wD", i), wD, tbl[i].e_wd);
            chk($sformatf("tbl%0d_cnt", i), 32'(fifo_cnt), 32'(tbl[i].e_cnt));
        end

        // Mid-stream asynchronous reset with three entries queued and a write in flight.
        for (int i = 0; i < 3; i++)
            step(1'b1, 5'd2, 32'hC0 + 32'(i), 1'b1, 5'(10 + i), 32'h200 + 32'(i), 5'd0, 5'd0);
        chk("mid_cnt_before", 32'(fifo_cnt), 32'd3);
        chk("mid_we_before", 32'(rf_we), 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(rf_we), 32'd0);
        chk("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("mid_rst_ready", 32'(b_ready), 32'd1);
        chk("mid_rst_hazard", 32'(b_hazard), 32'd0);
        chk("mid_rst_wR", 32'(wR), 32'd0);
        mq.delete();
        m_we = 1'b0; m_wr = 5'd0; m_wd = 32'd0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd12);

        // Back-to-back push/pop across pointer wrap.
        for (int i = 0; i < 10; i++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), 32'h300 + 32'(i), 5'(i), 5'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        for (int i = 0; i < 6; i++)
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
